// File: rtl/ucsbece154_cache_pkg.sv
// Shared definitions for the instruction cache: controller state encoding,
// default geometry and the address-field width helpers.
package ucsbece154_cache_pkg;

    localparam int DEF_NUM_SETS    = 8;
    localparam int DEF_NUM_WAYS    = 4;
    localparam int DEF_BLOCK_WORDS = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } cache_state_t;

    // Byte-offset field covers the word select plus the two byte bits.
    function automatic int offset_bits(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets, input int block_words);
        return 32 - index_bits(num_sets) - offset_bits(block_words);
    endfunction

endpackage

// File: rtl/ucsbece154_lru_tracker.sv
// True-LRU age store: one age per way per set, 0 = most recently used,
// NUM_WAYS-1 = least recently used (the victim).
module ucsbece154_lru_tracker
    import ucsbece154_cache_pkg::*;
#(
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    localparam int SET_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_access_en,
    input  logic [SET_W-1:0] i_access_set,
    input  logic [WAY_W-1:0] i_access_way,
    input  logic [SET_W-1:0] i_victim_set,
    output logic [WAY_W-1:0] o_victim_way
);

    logic [WAY_W-1:0] r_age [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] w_old_age;

    assign w_old_age = r_age[i_access_set][i_access_way];

    always_comb begin
        o_victim_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_age[i_victim_set][w] == WAY_W'(NUM_WAYS - 1)) begin
                o_victim_way = WAY_W'(w);
            end
        end
    end

    // Ages stay a permutation of 0..NUM_WAYS-1: only ways younger than the
    // accessed one move, so the oldest way is always unique.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else if (i_access_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == i_access_way) begin
                    r_age[i_access_set][w] <= '0;
                end else if (r_age[i_access_set][w] < w_old_age) begin
                    r_age[i_access_set][w] <= r_age[i_access_set][w] + WAY_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ucsbece154_icache_lru.sv
// Set-associative instruction cache with true-LRU replacement, in-order line
// refill with early restart, and deferred flush while a refill is in flight.
module ucsbece154_icache_lru
    import ucsbece154_cache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int NUM_WAYS    = DEF_NUM_WAYS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReadEnable,
    input  logic [31:0]  ReadAddress,
    input  logic         Flush,
    output logic [31:0]  Instruction,
    output logic         Ready,
    output logic         Busy,
    output logic [31:0]  MemReadAddress,
    output logic         MemReadRequest,
    input  logic [31:0]  MemDataIn,
    input  logic         MemDataReady,
    output logic [31:0]  HitCount,
    output logic [31:0]  MissCount,
    output cache_state_t o_dbg_state
);

    localparam int OFF_W  = offset_bits(BLOCK_WORDS);
    localparam int IDX_W  = index_bits(NUM_SETS);
    localparam int TAG_W  = tag_bits(NUM_SETS, BLOCK_WORDS);
    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int WAY_W  = $clog2(NUM_WAYS);

    cache_state_t      r_state;
    logic              r_ready;
    logic [31:0]       r_instr;
    logic              r_busy;
    logic              r_mem_req;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_hit_count;
    logic [31:0]       r_miss_count;
    logic              r_flush_pending;
    logic [TAG_W-1:0]  r_req_tag;
    logic [IDX_W-1:0]  r_req_index;
    logic [WORD_W-1:0] r_req_word;
    logic [WORD_W-1:0] r_word_cnt;

    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
    logic [31:0]         r_data  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [31:0]         r_line_buf [BLOCK_WORDS];

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_index;
    logic [WORD_W-1:0] w_word;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [31:0]       w_hit_word;
    logic              w_flush_now;
    logic              w_fill;
    logic              w_last_word;
    logic              w_lru_en;
    logic [IDX_W-1:0]  w_lru_set;
    logic [WAY_W-1:0]  w_lru_way;
    logic [WAY_W-1:0]  w_victim_lru;
    logic [WAY_W-1:0]  w_victim_way;
    logic              w_found_invalid;
    logic              w_unused;

    assign w_tag    = ReadAddress[31 -: TAG_W];
    assign w_index  = ReadAddress[OFF_W +: IDX_W];
    assign w_word   = ReadAddress[2 +: WORD_W];
    assign w_unused = ^ReadAddress[1:0];

    // A flush deferred from the refill acts exactly like a fresh Flush input.
    assign w_flush_now = Flush | r_flush_pending;
    assign w_last_word = (r_word_cnt == WORD_W'(BLOCK_WORDS - 1));
    assign w_fill      = (r_state == ST_REFILL) && MemDataReady && w_last_word && !Reset;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit_word = r_data[w_index][w_hit_way][w_word];

    always_comb begin
        w_victim_way    = w_victim_lru;
        w_found_invalid = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!w_found_invalid && !r_valid[r_req_index][w]) begin
                w_victim_way    = WAY_W'(w);
                w_found_invalid = 1'b1;
            end
        end
    end

    assign w_lru_en  = w_fill ||
                       ((r_state == ST_IDLE) && ReadEnable && w_hit && !w_flush_now);
    assign w_lru_set = (r_state == ST_REFILL) ? r_req_index  : w_index;
    assign w_lru_way = (r_state == ST_REFILL) ? w_victim_way : w_hit_way;

    ucsbece154_lru_tracker #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_access_en  (w_lru_en),
        .i_access_set (w_lru_set),
        .i_access_way (w_lru_way),
        .i_victim_set (r_req_index),
        .o_victim_way (w_victim_lru)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= ST_IDLE;
            r_ready         <= 1'b0;
            r_instr         <= '0;
            r_busy          <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_hit_count     <= '0;
            r_miss_count    <= '0;
            r_flush_pending <= 1'b0;
            r_req_tag       <= '0;
            r_req_index     <= '0;
            r_req_word      <= '0;
            r_word_cnt      <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
            end
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_flush_now) begin
                        for (int s = 0; s < NUM_SETS; s++) begin
                            r_valid[s] <= '0;
                        end
                        r_flush_pending <= 1'b0;
                    end
                    if (ReadEnable) begin
                        if (w_hit && !w_flush_now) begin
                            r_ready     <= 1'b1;
                            r_instr     <= w_hit_word;
                            r_hit_count <= r_hit_count + 32'd1;
                        end else begin
                            r_state      <= ST_REFILL;
                            r_busy       <= 1'b1;
                            r_mem_req    <= 1'b1;
                            r_mem_addr   <= {ReadAddress[31:OFF_W], {OFF_W{1'b0}}};
                            r_req_tag    <= w_tag;
                            r_req_index  <= w_index;
                            r_req_word   <= w_word;
                            r_word_cnt   <= '0;
                            r_miss_count <= r_miss_count + 32'd1;
                        end
                    end
                end
                ST_REFILL: begin
                    if (Flush) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (MemDataReady) begin
                        if (r_word_cnt == r_req_word) begin
                            r_ready <= 1'b1;
                            r_instr <= MemDataIn;
                        end
                        r_word_cnt <= r_word_cnt + WORD_W'(1);
                        if (w_last_word) begin
                            r_valid[r_req_index][w_victim_way] <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Tag/data storage carries no reset; valid bits alone qualify it.
    always_ff @(posedge Clk) begin
        if ((r_state == ST_REFILL) && MemDataReady) begin
            r_line_buf[r_word_cnt] <= MemDataIn;
        end
        if (w_fill) begin
            r_tag[r_req_index][w_victim_way] <= r_req_tag;
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                r_data[r_req_index][w_victim_way][k] <=
                    (k == BLOCK_WORDS - 1) ? MemDataIn : r_line_buf[k];
            end
        end
    end

    assign Instruction    = r_instr;
    assign Ready          = r_ready;
    assign Busy           = r_busy;
    assign MemReadAddress = r_mem_addr;
    assign MemReadRequest = r_mem_req;
    assign HitCount       = r_hit_count;
    assign MissCount      = r_miss_count;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ucsbece154_icache_lru.sv
// Directed bench for the LRU instruction cache: expected instruction words are
// queued at request time and popped whenever the cache raises Ready.
module tb_ucsbece154_icache_lru;
    import ucsbece154_cache_pkg::*;

    logic         Clk;
    logic         Reset;
    logic         ReadEnable;
    logic [31:0]  ReadAddress;
    logic         Flush;
    logic [31:0]  Instruction;
    logic         Ready;
    logic         Busy;
    logic [31:0]  MemReadAddress;
    logic         MemReadRequest;
    logic [31:0]  MemDataIn;
    logic         MemDataReady;
    logic [31:0]  HitCount;
    logic [31:0]  MissCount;
    cache_state_t dbg_state;

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hits = 0;
    logic [31:0] exp_misses = 0;

    ucsbece154_icache_lru dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Flush          (Flush),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .Busy           (Busy),
        .MemReadAddress (MemReadAddress),
        .MemReadRequest (MemReadRequest),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady),
        .HitCount       (HitCount),
        .MissCount      (MissCount),
        .o_dbg_state    (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        return {wa[15:0] ^ 16'hBEEF, wa[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every Ready pulse must match the oldest outstanding request.
    always @(negedge Clk) begin
        if (Ready === 1'b1) begin
            check("ready_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("instruction", Instruction, exp_q.pop_front());
            end
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the sampling edge.
    task automatic start_read(input logic [31:0] addr, input bit push, input bit flush);
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        Flush       = flush;
        if (push) exp_q.push_back(word_of(addr));
        @(posedge Clk); #1;
        ReadEnable = 1'b0;
        Flush      = 1'b0;
    endtask

    task automatic serve_line(input logic [31:0] line, input int req_word, input int nwords,
                              input bit flush_at_1, input bit poke_re);
        for (int k = 0; k < nwords; k++) begin
            repeat ($urandom_range(0, 2)) begin
                ReadEnable  = poke_re;
                ReadAddress = 32'h0000_0000;
                @(posedge Clk); #1;
            end
            ReadEnable   = poke_re;
            ReadAddress  = 32'h0000_0000;
            MemDataReady = 1'b1;
            MemDataIn    = word_of(line + 32'(4 * k));
            Flush        = flush_at_1 && (k == 1);
            @(posedge Clk); #1;
            MemDataReady = 1'b0;
            Flush        = 1'b0;
            ReadEnable   = 1'b0;
            if (k == req_word) check("early_restart_ready", {31'd0, Ready}, 32'd1);
            if (k < 3) check("busy_during_refill", {31'd0, Busy}, 32'd1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge Clk); #1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_miss(input logic [31:0] addr, input bit flush_start, input bit flush_mid,
                           input bit poke_re);
        logic [31:0] line;
        line = addr & 32'hFFFF_FFF0;
        start_read(addr, 1'b1, flush_start);
        exp_misses++;
        check("miss_busy", {31'd0, Busy}, 32'd1);
        check("miss_memreq", {31'd0, MemReadRequest}, 32'd1);
        check("miss_memaddr", MemReadAddress, line);
        serve_line(line, int'(addr[3:2]), 4, flush_mid, poke_re);
        check("refill_done_busy", {31'd0, Busy}, 32'd0);
        check("refill_done_memreq", {31'd0, MemReadRequest}, 32'd0);
        wait_drain();
        check("miss_count", MissCount, exp_misses);
    endtask

    task automatic do_hit(input logic [31:0] addr);
        start_read(addr, 1'b1, 1'b0);
        exp_hits++;
        check("hit_ready", {31'd0, Ready}, 32'd1);
        check("hit_busy", {31'd0, Busy}, 32'd0);
        check("hit_memreq", {31'd0, MemReadRequest}, 32'd0);
        wait_drain();
        check("hit_count", HitCount, exp_hits);
    endtask

    initial begin
        Reset        = 1'b1;
        ReadEnable   = 1'b0;
        ReadAddress  = '0;
        Flush        = 1'b0;
        MemDataIn    = '0;
        MemDataReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_instruction", Instruction, 32'd0);
        check("rst_ready", {31'd0, Ready}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_memreq", {31'd0, MemReadRequest}, 32'd0);
        check("rst_memaddr", MemReadAddress, 32'd0);
        check("rst_hitcount", HitCount, 32'd0);
        check("rst_misscount", MissCount, 32'd0);
        check("rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Cold miss with early restart on word 1; reads during refill ignored.
        do_miss(32'h0000_0044, 1'b0, 1'b0, 1'b1);
        do_hit(32'h0000_0048);

        // Flush in idle, then a flush landing in the middle of a refill.
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        do_miss(32'h0000_0048, 1'b0, 1'b1, 1'b0);
        do_miss(32'h0000_0048, 1'b0, 1'b0, 1'b0);

        // Fill set 0, touch way 0, then the LRU way (line 0x080) is evicted.
        do_miss(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        do_miss(32'h0000_0080, 1'b0, 1'b0, 1'b0);
        do_miss(32'h0000_0100, 1'b0, 1'b0, 1'b0);
        do_miss(32'h0000_0180, 1'b0, 1'b0, 1'b0);
        do_hit(32'h0000_0004);
        do_miss(32'h0000_0200, 1'b0, 1'b0, 1'b0);
        do_hit(32'h0000_0188);
        do_miss(32'h0000_008C, 1'b0, 1'b0, 1'b0);
        do_hit(32'h0000_000C);

        // Flush coincident with a read of a cached line forces a miss.
        do_miss(32'h0000_0008, 1'b1, 1'b0, 1'b0);

        // Line 0x40 was flushed: miss on word 3, then reset after two words.
        start_read(32'h0000_004C, 1'b0, 1'b0);
        check("abort_busy", {31'd0, Busy}, 32'd1);
        serve_line(32'h0000_0040, 3, 2, 1'b0, 1'b0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("abort_busy_low", {31'd0, Busy}, 32'd0);
        check("abort_memreq_low", {31'd0, MemReadRequest}, 32'd0);
        check("abort_hitcount", HitCount, 32'd0);
        check("abort_misscount", MissCount, 32'd0);
        exp_hits   = 0;
        exp_misses = 0;
        for (int k = 2; k < 4; k++) begin
            MemDataReady = 1'b1;
            MemDataIn    = word_of(32'h0000_0040 + 32'(4 * k));
            @(posedge Clk); #1;
            MemDataReady = 1'b0;
        end
        check("stray_data_busy", {31'd0, Busy}, 32'd0);
        do_miss(32'h0000_0044, 1'b0, 1'b0, 1'b0);
        do_hit(32'h0000_0040);

        repeat (5) @(posedge Clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
